// File: rtl/fmul_arbiter.sv
// Shares one fixed-latency pipelined fmul among NREQ requesters; a tag pipe routes each product back to its issuer.
// Build option: define FMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fmul_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 3,
   parameter int IDW  = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hold,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [32*NREQ-1:0] req_op1,
   input  logic [32*NREQ-1:0] req_op2,
   output logic [NREQ-1:0]    req_ready,
   output logic [31:0]        mul_op1,
   output logic [31:0]        mul_op2,
   input  logic [31:0]        mul_result,
   output logic [NREQ-1:0]    resp_valid,
   output logic [31:0]        resp_data,
   output logic               busy
);

   logic [IDW-1:0]  ptr;
   logic            grant_any;
   logic [IDW-1:0]  grant_id;
   logic [31:0]     sel_op1;
   logic [31:0]     sel_op2;
   logic [LAT-1:0]  tag_vld;
   logic [IDW-1:0]  tag_id [LAT];
   logic [NREQ-1:0] resp_onehot;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      req_ready = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      if (!hold) begin
         for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
               if (!grant_any && req_valid[i] && (i == (int'(ptr) + k) % NREQ)) begin
                  req_ready[i] = 1'b1;
                  grant_id     = IDW'(i);
                  grant_any    = 1'b1;
               end
            end
         end
      end
   end

   // With no grant the operands fall to zero, so the fmul computes a harmless 0.
   always_comb begin
      sel_op1 = '0;
      sel_op2 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_op1 = req_op1[32*i +: 32];
            sel_op2 = req_op2[32*i +: 32];
         end
      end
   end

`ifdef FMUL_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mul_op1    <= '0;
         mul_op2    <= '0;
         tag_vld    <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
      end else begin
         mul_op1 <= sel_op1;
         mul_op2 <= sel_op2;
         tag_vld <= (tag_vld << 1) | LAT'(grant_any);
         if (tag_vld[LAT-1]) begin
            resp_valid <= resp_onehot;
            resp_data  <= mul_result;
         end else begin
            resp_valid <= '0;
         end
      end
   end

   // NOTE: tag ids are always qualified by tag_vld, so this storage carries no reset.
   always_ff @(posedge clk) begin
      tag_id[0] <= grant_id;
      for (int s = 1; s < LAT; s++) begin
         tag_id[s] <= tag_id[s-1];
      end
   end

   always_comb begin
      resp_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         resp_onehot[i] = (tag_id[LAT-1] == IDW'(i));
      end
   end

   assign busy = (|tag_vld) || (|resp_valid);

endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter: a grant model pushes expected responses, a monitor pops and compares.
// Honours FMUL_ARB_FIXED_PRIO_EN the same way the design does.
module tb_fmul_arbiter;

   localparam int NREQ = 4;
   localparam int LAT  = 3;
   localparam int IDW  = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic               hold;
   logic [NREQ-1:0]    req_valid;
   logic [32*NREQ-1:0] req_op1;
   logic [32*NREQ-1:0] req_op2;
   logic [NREQ-1:0]    req_ready;
   logic [31:0]        mul_op1;
   logic [31:0]        mul_op2;
   logic [31:0]        mul_result;
   logic [NREQ-1:0]    resp_valid;
   logic [31:0]        resp_data;
   logic               busy;

   fmul_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .req_valid (req_valid),
      .req_op1   (req_op1),
      .req_op2   (req_op2),
      .req_ready (req_ready),
      .mul_op1   (mul_op1),
      .mul_op2   (mul_op2),
      .mul_result(mul_result),
      .resp_valid(resp_valid),
      .resp_data (resp_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic chk_en = 1'b0;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Single-precision multiply for normal operands and zero, truncating.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      int          e;
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
      m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) begin
         m = m >> 1;
         e++;
      end
      return {a[31] ^ b[31], e[7:0], m[45:23]};
   endfunction

   // Behavioural fmul: mul_op register is the capture edge, LAT-1 more registers follow.
   logic [31:0] fm_pipe [LAT-1];
   always @(posedge clk) begin
      fm_pipe[0] <= fp_mul(mul_op1, mul_op2);
      for (int k = 1; k < LAT - 1; k++) fm_pipe[k] <= fm_pipe[k-1];
   end
   assign mul_result = fm_pipe[LAT-2];

   always @(posedge clk) cyc <= cyc + 1;

   // Grant model: checks req_ready and mul_op, and queues the response each grant must produce.
   int          m_ptr   = 0;
   logic [31:0] exp_op1 = '0;
   logic [31:0] exp_op2 = '0;
   always @(negedge clk) begin
      if (chk_en) begin
         int              g;
         logic [NREQ-1:0] er;
         check("mul_op1", mul_op1, exp_op1);
         check("mul_op2", mul_op2, exp_op2);
         g  = -1;
         er = '0;
         if (!hold) begin
            for (int k = 0; k < NREQ; k++) begin
               int idx;
               idx = (m_ptr + k) % NREQ;
               if (g < 0 && req_valid[idx]) g = idx;
            end
         end
         if (g >= 0) er[g] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(er));
         if (!reset) begin
            m_ptr   = 0;
            exp_op1 = '0;
            exp_op2 = '0;
         end else if (g >= 0) begin
            exp_op1 = req_op1[32*g +: 32];
            exp_op2 = req_op2[32*g +: 32];
            sb.push_back('{id: g, data: fp_mul(exp_op1, exp_op2), due: cyc + LAT + 1});
`ifdef FMUL_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (g + 1) % NREQ;
`endif
         end else begin
            exp_op1 = '0;
            exp_op2 = '0;
         end
      end
   end

   // Monitor: pops the scoreboard when a response is due and checks busy.
   always @(negedge clk) begin
      if (chk_en) begin
         logic            exp_busy;
         logic [NREQ-1:0] ev;
         exp_t            e;
         exp_busy = 1'b0;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e  = sb.pop_front();
            ev = '0;
            ev[e.id] = 1'b1;
            check("resp_valid", 32'(resp_valid), 32'(ev));
            check("resp_data", resp_data, e.data);
            exp_busy = 1'b1;
         end else begin
            check("resp_idle", 32'(resp_valid), 32'd0);
         end
         foreach (sb[j]) if (sb[j].due <= cyc + LAT) exp_busy = 1'b1;
         check("busy", 32'(busy), 32'(exp_busy));
         if (!reset) sb.delete();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic [31:0] a, input logic [31:0] b);
      req_valid[i]        = 1'b1;
      req_op1[32*i +: 32] = a;
      req_op2[32*i +: 32] = b;
   endtask

   function automatic logic [31:0] rnd_op();
      logic [31:0] tab [7];
      logic [31:0] v;
      tab = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000,
              32'h3F000000, 32'h3FA00000, 32'h00000000};
      v = tab[$urandom_range(0, 6)];
      v[31] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   initial begin
      logic [31:0] b2b_op2 [5];
      b2b_op2 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
      reset     = 1'b0;
      hold      = 1'b0;
      req_valid = '0;
      req_op1   = '0;
      req_op2   = '0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      step();
      reset = 1'b1;
      @(negedge clk);
      check("reset_resp_data", resp_data, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      step();

      // Single op: 2.0 * 3.0.
      put(0, 32'h40000000, 32'h40400000);
      step();
      req_valid = '0;
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      check("single_resp_valid", 32'(resp_valid), 32'h1);
      check("single_resp_data", resp_data, 32'h40C00000);
      step();

      // Round-robin: all requesters valid with 1.5 * 1.5.
      for (int i = 0; i < NREQ; i++) put(i, 32'h3FC00000, 32'h3FC00000);
      repeat (8) step();
      req_valid = '0;
      repeat (LAT + 2) step();

      // Back-to-back from requester 2.
      for (int j = 0; j < 5; j++) begin
         put(2, 32'h3F800000, b2b_op2[j]);
         step();
      end
      req_valid = '0;
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      check("b2b_last_valid", 32'(resp_valid), 32'h4);
      check("b2b_last_data", resp_data, 32'h40A00000);
      step();

      // Hold with requester 1 waiting.
      put(0, 32'h40000000, 32'h40000000);
      put(1, 32'h40400000, 32'h3F800000);
      repeat (2) step();
      req_valid = 4'b0010;
      hold = 1'b1;
      repeat (3) step();
      hold = 1'b0;
      #1 check("hold_release_grant", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      repeat (LAT + 2) step();

      // Reset with three ops in flight.
      for (int i = 0; i < 3; i++) put(i, 32'h3FC00000, 32'h40000000);
      repeat (3) step();
      req_valid = '0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("midrst_mul_op1", mul_op1, 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (LAT + 2) step();

      // Zero operand.
      put(3, 32'h00000000, 32'h40490FDB);
      step();
      req_valid = '0;
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      check("zero_resp_valid", 32'(resp_valid), 32'h8);
      check("zero_resp_data", resp_data, 32'h00000000);
      step();

`ifdef FMUL_ARB_FIXED_PRIO_EN
      put(0, 32'h3F800000, 32'h40000000);
      put(3, 32'h40000000, 32'h40000000);
      repeat (8) step();
      req_valid = '0;
      repeat (LAT + 2) step();
`endif

      // Random traffic with occasional hold.
      repeat (400) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 1) == 1) put(i, rnd_op(), rnd_op());
            else req_valid[i] = 1'b0;
         end
         hold = ($urandom_range(0, 5) == 0);
         step();
      end
      req_valid = '0;
      hold = 1'b0;

      for (int t = 0; t < 32 && sb.size() != 0; t++) step();
      check("drain_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
